// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider for 8086 DIV/IDIV (byte and word forms).
// Launch with start; a single done pulse carries div_exc, and out holds the last good result.
module alu_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [15:0] y,
  input  logic        word_op,
  input  logic        signed_op,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        div_exc
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q;
  logic [15:0] y_q;
  logic        word_q, sgn_q;
  logic [15:0] rem_q, quot_q;
  logic [4:0]  cnt_q;
  logic [31:0] out_q, out_d;
  logic        busy_q, busy_d, done_q, done_d, exc_q, exc_d;

  logic        dvd_neg_s, dvs_neg_s, neg_q_s, prep_exc_s, range_exc_s, no_borrow_s;
  logic [31:0] dvd_mag_s, fix_out_s;
  logic [15:0] dvs_mag_s, hi_s, lo_s, q_mag_s, q_lim_s, q_res_s, r_res_s, diff_s;
  logic [16:0] shl_s;

  // Magnitudes, restoring step and sign fix-up, all from captured operands
  always_comb begin
    dvd_neg_s = sgn_q & (word_q ? x_q[31] : x_q[15]);
    dvs_neg_s = sgn_q & (word_q ? y_q[15] : y_q[7]);
    if (dvd_neg_s) begin
      dvd_mag_s = word_q ? (32'd0 - x_q) : {16'd0, 16'd0 - x_q[15:0]};
    end else begin
      dvd_mag_s = word_q ? x_q : {16'd0, x_q[15:0]};
    end
    if (dvs_neg_s) begin
      dvs_mag_s = word_q ? (16'd0 - y_q) : {8'd0, 8'd0 - y_q[7:0]};
    end else begin
      dvs_mag_s = word_q ? y_q : {8'd0, y_q[7:0]};
    end
    // Byte mode keeps the dividend low half left-aligned so quot_q[15] always feeds the shift
    hi_s        = word_q ? dvd_mag_s[31:16] : {8'd0, dvd_mag_s[15:8]};
    lo_s        = word_q ? dvd_mag_s[15:0]  : {dvd_mag_s[7:0], 8'd0};
    prep_exc_s  = (dvs_mag_s == 16'd0) || (hi_s >= dvs_mag_s);
    shl_s       = {rem_q, quot_q[15]};
    no_borrow_s = (shl_s >= {1'b0, dvs_mag_s});
    diff_s      = shl_s[15:0] - dvs_mag_s;
    neg_q_s     = dvd_neg_s ^ dvs_neg_s;
    q_mag_s     = word_q ? quot_q : {8'd0, quot_q[7:0]};
    if (word_q) begin
      q_lim_s = neg_q_s ? 16'h8000 : 16'h7FFF;
    end else begin
      q_lim_s = neg_q_s ? 16'h0080 : 16'h007F;
    end
    range_exc_s = sgn_q & (q_mag_s > q_lim_s);
    q_res_s     = neg_q_s ? (16'd0 - q_mag_s) : q_mag_s;
    r_res_s     = dvd_neg_s ? (16'd0 - rem_q) : rem_q;
    fix_out_s   = word_q ? {r_res_s, q_res_s} : {16'd0, r_res_s[7:0], q_res_s[7:0]};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_PREP : S_IDLE;
      S_PREP:  state_d = prep_exc_s ? S_DONE : S_RUN;
      S_RUN:   state_d = (cnt_q == 5'd1) ? S_FIX : S_RUN;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values, registered alongside the state
  always_comb begin
    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
    if (state_q == S_PREP) begin
      exc_d = prep_exc_s;
    end else if (state_q == S_FIX) begin
      exc_d = range_exc_s;
    end else begin
      exc_d = 1'b0;
    end
    if ((state_q == S_FIX) && !range_exc_s) begin
      out_d = fix_out_s;
    end else begin
      out_d = out_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

  // Operand capture and shift/subtract datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= 32'd0;
      y_q    <= 16'd0;
      word_q <= 1'b0;
      sgn_q  <= 1'b0;
      rem_q  <= 16'd0;
      quot_q <= 16'd0;
      cnt_q  <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q    <= x;
            y_q    <= y;
            word_q <= word_op;
            sgn_q  <= signed_op;
          end
        end
        S_PREP: begin
          rem_q  <= hi_s;
          quot_q <= lo_s;
          cnt_q  <= word_q ? 5'd16 : 5'd8;
        end
        S_RUN: begin
          rem_q  <= no_borrow_s ? diff_s : shl_s[15:0];
          quot_q <= {quot_q[14:0], no_borrow_s};
          cnt_q  <= cnt_q - 5'd1;
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign div_exc = done_q & exc_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed and random bench for alu_div_seq against an arithmetic reference model.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, word_op, signed_op;
  logic [31:0] x;
  logic [15:0] y;
  logic [31:0] out;
  logic        busy, done, div_exc;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_out;

  alu_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .word_op(word_op), .signed_op(signed_op),
    .out(out), .busy(busy), .done(done), .div_exc(div_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero
  task automatic model(input logic [31:0] xv, input logic [15:0] yv, input bit w, input bit s,
                       output int lat, output bit exc, output logic [31:0] res);
    longint dvd, dvs, ad, as, q, r, one;
    int n;
    one = 1;
    n   = w ? 16 : 8;
    if (s) begin
      dvd = w ? {{32{xv[31]}}, xv} : {{48{xv[15]}}, xv[15:0]};
      dvs = w ? {{48{yv[15]}}, yv} : {{56{yv[7]}}, yv[7:0]};
    end else begin
      dvd = w ? {32'd0, xv} : {48'd0, xv[15:0]};
      dvs = w ? {48'd0, yv} : {56'd0, yv[7:0]};
    end
    ad  = (dvd < 0) ? -dvd : dvd;
    as  = (dvs < 0) ? -dvs : dvs;
    res = 32'd0;
    if (as == 0 || (ad / as) >= (one << n)) begin
      lat = 1;
      exc = 1'b1;
    end else begin
      q   = dvd / dvs;
      r   = dvd % dvs;
      lat = n + 2;
      exc = s && (q < -(one << (n - 1)) || q > (one << (n - 1)) - 1);
      res = w ? {r[15:0], q[15:0]} : {16'd0, r[7:0], q[7:0]};
    end
  endtask

  task automatic run_op(input logic [31:0] xv, input logic [15:0] yv, input bit w, input bit s,
                        input int restart_at, input string tag);
    int lat, k;
    bit exc, seen;
    logic [31:0] res;
    model(xv, yv, w, s, lat, exc, res);
    @(negedge clk);
    x = xv; y = yv; word_op = w; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = $urandom; y = 16'($urandom); word_op = 1'($urandom); signed_op = 1'($urandom);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      if (k == restart_at - 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (done) seen = 1'b1;
      else chk({tag, " busy"}, 32'(busy), 32'd1);
    end
    chk({tag, " latency"}, 32'(k), 32'(lat));
    chk({tag, " div_exc"}, 32'(div_exc), 32'(exc));
    if (!exc) last_out = res;
    chk({tag, " out"}, out, last_out);
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, " single done"}, 32'(done), 32'd0);
    chk({tag, " exc cleared"}, 32'(div_exc), 32'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] xr;
    logic [15:0] yr;
    rst = 1'b1; start = 1'b0; x = 32'd0; y = 16'd0; word_op = 1'b0; signed_op = 1'b0;
    last_out = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out", out, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset exc", 32'(div_exc), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h0000_0064, 16'h0007, 1'b0, 1'b0, 0, "ubyte");
    run_op(32'hFFFF_FF9C, 16'h0007, 1'b1, 1'b1, 0, "sword");
    chk("sword value", out, 32'hFFFE_FFF2);
    run_op(32'h0000_FF80, 16'h0001, 1'b0, 1'b1, 0, "sbyte");
    chk("sbyte value", out, 32'h0000_0080);
    run_op(32'h0001_0000, 16'h0003, 1'b1, 1'b0, 0, "uword");
    chk("uword value", out, 32'h0001_5555);
    run_op(32'h0001_0000, 16'h0000, 1'b1, 1'b0, 0, "div0");
    chk("div0 keeps out", out, 32'h0001_5555);
    run_op(32'h0003_0000, 16'h0003, 1'b1, 1'b0, 0, "uovf");
    run_op(32'h0000_FF80, 16'h00FF, 1'b0, 1'b1, 0, "srange");
    chk("srange keeps out", out, 32'h0001_5555);
    run_op(32'h1234_5678, 16'h9ABC, 1'b1, 1'b0, 5, "restart");

    // Abort a word divide mid-run
    @(negedge clk);
    x = 32'h0001_0000; y = 16'h0003; word_op = 1'b1; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort out", out, 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_out = 32'd0;
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    run_op(32'h0001_0000, 16'h0003, 1'b1, 1'b0, 0, "after reset");

    for (int i = 0; i < 40; i++) begin
      xr = $urandom;
      if ($urandom_range(0, 1) == 1) xr = xr >> $urandom_range(8, 24);
      yr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) yr = yr & 16'h00FF;
      run_op(xr, yr, 1'($urandom), 1'($urandom), 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
